// File: rtl/fsk_serializer_param_pkg.sv
// Shared types and width helpers for the FSK serializer.
//   fsk_ser_state_t : frame state (idle, sync field, data field)
//   max_int         : larger of two ints, usable in constant expressions
//   bit_cnt_w       : bit-counter width that covers the longer of the two fields
package fsk_serializer_param_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA
  } fsk_ser_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int bit_cnt_w(input int sync_w, input int data_w);
    return $clog2(max_int(sync_w, data_w) + 1);
  endfunction

endpackage

// File: rtl/fsk_serializer_param_if.sv
// Handshake and serial-output bundle of the FSK serializer.
//   in_data/in_valid/in_ready : word input with valid/ready handshake
//   ser_out/ser_active        : serial bit and "bit on the line" flag
//   frame_start/frame_done    : one-cycle frame boundary pulses
// master = word producer / serial consumer, slave = the serializer.
interface fsk_serializer_param_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_active;
  logic              frame_start;
  logic              frame_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_active, frame_start, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_active, frame_start, frame_done
  );
endinterface

// File: rtl/fsk_serializer_param_bit_tick.sv
// Free-running bit-rate divider: cnt counts 0..DIV-1 and wraps, tick is high
// for the one clk cycle in which cnt == DIV-1. Shared with the demodulator.
//   clk   : system clock
//   reset : asynchronous reset, active-high (clears the counter)
//   tick  : one-cycle bit-rate enable
module fsk_bit_tick #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fsk_serializer_param.sv
// Parallel-to-serial converter for the FSK modulator control input.
// A one-word holding buffer takes words on the valid/ready handshake; each
// word goes out as an optional sync field followed by DATA_W data bits, every
// bit held DIV clk cycles. Back-to-back frames follow with no gap bit.
//   clk   : system clock
//   reset : asynchronous reset, active-high; drops any partial frame
//   bus   : slave side of fsk_serializer_param_if (handshake + serial out)
module fsk_serializer_param
  import fsk_serializer_param_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          DIV       = 16,
  parameter int          SYNC_W    = 8,
  parameter logic [31:0] SYNC_PAT  = 32'h0000_00A5,
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic        IDLE_LVL  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  fsk_serializer_param_if.slave  bus
);
  // A zero-length sync field still needs a legal 1-bit vector; it is never sent.
  localparam int                  SYNC_LEN  = (SYNC_W > 0) ? SYNC_W : 1;
  localparam int                  CNT_W     = bit_cnt_w(SYNC_W, DATA_W);
  localparam logic [SYNC_LEN-1:0] SYNC_VEC  = SYNC_PAT[SYNC_LEN-1:0];
  localparam logic [CNT_W-1:0]    SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_W - 1);

  logic tick;

  fsk_bit_tick #(.DIV(DIV)) u_bit_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // The bit on the line is always taken from the head of a shift register;
  // the register is shifted on the same edge so the next bit is at the head.
  function automatic logic data_head(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] data_shift(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic sync_head(input logic [SYNC_LEN-1:0] v);
    return MSB_FIRST ? v[SYNC_LEN-1] : v[0];
  endfunction

  function automatic logic [SYNC_LEN-1:0] sync_shift(input logic [SYNC_LEN-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  fsk_ser_state_t      state_q, state_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [SYNC_LEN-1:0] sync_sr_q, sync_sr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                ser_out_q, ser_out_d;
  logic                ser_active_q, ser_active_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic                accept;
  logic                load;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    state_d       = state_q;
    buf_d         = buf_q;
    shreg_d       = shreg_q;
    sync_sr_d     = sync_sr_q;
    bit_cnt_d     = bit_cnt_q;
    ser_out_d     = ser_out_q;
    ser_active_d  = ser_active_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    load          = 1'b0;

    accept = bus.in_valid & ~buf_full_q;

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (buf_full_q) load = 1'b1;
        end
        S_SYNC: begin
          if (bit_cnt_q == SYNC_LAST) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            ser_out_d = data_head(shreg_q);
            shreg_d   = data_shift(shreg_q);
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            ser_out_d = sync_head(sync_sr_q);
            sync_sr_d = sync_shift(sync_sr_q);
          end
        end
        S_DATA: begin
          if (bit_cnt_q == DATA_LAST) begin
            frame_done_d = 1'b1;
            if (buf_full_q) begin
              load = 1'b1;          // chain the next frame with no gap bit
            end else begin
              state_d      = S_IDLE;
              ser_out_d    = IDLE_LVL;
              ser_active_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            ser_out_d = data_head(shreg_q);
            shreg_d   = data_shift(shreg_q);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Frame launch: the buffered word moves into the shifter and bit 0 of
    // the first field goes on the line at once.
    if (load) begin
      frame_start_d = 1'b1;
      ser_active_d  = 1'b1;
      bit_cnt_d     = '0;
      if (SYNC_W > 0) begin
        state_d   = S_SYNC;
        ser_out_d = sync_head(SYNC_VEC);
        sync_sr_d = sync_shift(SYNC_VEC);
        shreg_d   = buf_q;
      end else begin
        state_d   = S_DATA;
        ser_out_d = data_head(buf_q);
        shreg_d   = data_shift(buf_q);
      end
    end

    // load needs buf_full_q=1 and accept needs buf_full_q=0, so they never
    // coincide: a word offered on the load edge waits one more cycle.
    if (load)        buf_full_d = 1'b0;
    else if (accept) buf_full_d = 1'b1;
    else             buf_full_d = buf_full_q;

    if (accept) buf_d = bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      // NOTE: the word buffer and shifter are reset as well, so no stale word can leak into a frame.
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      shreg_q       <= '0;
      sync_sr_q     <= '0;
      bit_cnt_q     <= '0;
      ser_out_q     <= IDLE_LVL;
      ser_active_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      shreg_q       <= shreg_d;
      sync_sr_q     <= sync_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      ser_out_q     <= ser_out_d;
      ser_active_q  <= ser_active_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.in_ready    = ~buf_full_q;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_active  = ser_active_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_fsk_serializer_param.sv
// Directed bench for fsk_serializer_param with three parameter sets:
//   u0 default (LSB first, A5 sync, DIV 16), u1 MSB first without sync,
//   u2 DIV 2, 4-bit words, no sync.
module tb_fsk_serializer_param;
  localparam logic IDLE = 1'b0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fsk_serializer_param_if #(.DATA_W(16)) if0 ();
  fsk_serializer_param_if #(.DATA_W(16)) if1 ();
  fsk_serializer_param_if #(.DATA_W(4))  if2 ();

  fsk_serializer_param u0 (.clk(clk), .reset(reset), .bus(if0));
  fsk_serializer_param #(.MSB_FIRST(1'b1), .SYNC_W(0)) u1 (.clk(clk), .reset(reset), .bus(if1));
  fsk_serializer_param #(.DIV(2), .DATA_W(4), .SYNC_W(0)) u2 (.clk(clk), .reset(reset), .bus(if2));

  int   passed = 0;
  int   total  = 0;
  logic exp_bits [0:63];
  int   fs_cnt, fd_cnt, acc_cnt;
  bit   offering = 1'b0;

  // Expected u0 frame: A5 sync LSB first, then the data word LSB first.
  task automatic fill_frame0(input int base, input logic [15:0] w);
    logic [7:0] sp;
    sp = 8'hA5;
    for (int i = 0; i < 8; i++)  exp_bits[base + i] = sp[i];
    for (int i = 0; i < 16; i++) exp_bits[base + 8 + i] = w[i];
  endtask

  task automatic offer0(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if0.in_data  = w;
    if0.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!if0.in_ready) ok = 1'b1;
    end
    if0.in_valid = 1'b0;
    total++;
    if (!ok) $display("FAIL u0_accept: in_ready stayed 1, required 0 after accepting %h", w);
    else passed++;
  endtask

  task automatic wait_start0(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(negedge clk);
      if (if0.frame_start) begin
        found = 1'b1;
        n = i;
      end
    end
    total++;
    if (!found) $display("FAIL u0_frame_start_timeout: no frame_start within 200 clk, required one");
    else passed++;
  endtask

  // Starts on the sample where frame_start is seen; each bit is checked on
  // all 16 of its samples, then the sample after the last bit must show the
  // frame_done pulse and the idle line.
  task automatic check_stream0(input string name, input int nbits, input int offer_at,
                               input logic [15:0] offer_word);
    bit bad;
    bad = 1'b0;
    fs_cnt = 0; fd_cnt = 0; acc_cnt = 0;
    for (int k = 0; k < nbits * 16; k++) begin
      if (k > 0) @(negedge clk);
      if (k == offer_at) begin
        if0.in_data  = offer_word;
        if0.in_valid = 1'b1;
        offering     = 1'b1;
      end else if (offering && !if0.in_ready) begin
        if0.in_valid = 1'b0;
        offering     = 1'b0;
        acc_cnt++;
      end
      if (if0.frame_start) fs_cnt++;
      if (if0.frame_done)  fd_cnt++;
      if (if0.ser_out !== exp_bits[k / 16] || if0.ser_active !== 1'b1) bad = 1'b1;
      if (k % 16 == 15) begin
        total++;
        if (bad) $display("FAIL %s_bit%0d: ser_out=%b active=%b, required ser_out=%b active=1 for 16 clk",
                          name, k / 16, if0.ser_out, if0.ser_active, exp_bits[k / 16]);
        else passed++;
        bad = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if ({if0.frame_done, if0.ser_out, if0.ser_active} !== {1'b1, IDLE, 1'b0})
      $display("FAIL %s_end: done/ser/active=%b%b%b, required 1%b0",
               name, if0.frame_done, if0.ser_out, if0.ser_active, IDLE);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({if0.ser_out, if0.in_ready, if0.ser_active, if0.frame_start, if0.frame_done} !== {IDLE, 4'b1000})
      $display("FAIL reset_u0: outputs=%b, required %b1000", {if0.ser_out, if0.in_ready,
               if0.ser_active, if0.frame_start, if0.frame_done}, IDLE);
    else passed++;
    total++;
    if ({if1.ser_out, if1.in_ready, if1.ser_active, if1.frame_start, if1.frame_done} !== {IDLE, 4'b1000})
      $display("FAIL reset_u1: outputs=%b, required %b1000", {if1.ser_out, if1.in_ready,
               if1.ser_active, if1.frame_start, if1.frame_done}, IDLE);
    else passed++;
    total++;
    if ({if2.ser_out, if2.in_ready, if2.ser_active, if2.frame_start, if2.frame_done} !== {IDLE, 4'b1000})
      $display("FAIL reset_u2: outputs=%b, required %b1000", {if2.ser_out, if2.in_ready,
               if2.ser_active, if2.frame_start, if2.frame_done}, IDLE);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_lsb();
    int n;
    fill_frame0(0, 16'h8001);
    offer0(16'h8001);
    wait_start0(n);
    total++;
    if (n < 1 || n > 16) $display("FAIL lsb_latency: %0d clk, required 1..16", n);
    else passed++;
    check_stream0("lsb", 24, -1, 16'h0000);
    total++;
    if (fs_cnt != 1 || fd_cnt != 0)
      $display("FAIL lsb_pulses: frame_start=%0d frame_done=%0d in frame, required 1 and 0", fs_cnt, fd_cnt);
    else passed++;
    @(negedge clk);
    total++;
    if (if0.frame_done !== 1'b0) $display("FAIL lsb_done_width: frame_done=%b second cycle, required 0", if0.frame_done);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int  n;
    bit  bad;
    offer0(16'h1234);
    wait_start0(n);
    // 8 sync bits + 7 data bits = 240 samples; land inside data bit 7.
    repeat (245) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({if0.ser_out, if0.in_ready, if0.ser_active, if0.frame_done} !== {IDLE, 3'b100})
      $display("FAIL midreset_outputs: ser/ready/active/done=%b, required %b100",
               {if0.ser_out, if0.in_ready, if0.ser_active, if0.frame_done}, IDLE);
    else passed++;
    reset = 1'b0;
    bad = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (if0.frame_done || if0.ser_active || !if0.in_ready) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL midreset_dropped: frame activity after reset, required none");
    else passed++;
  endtask

  task automatic test_msb_nosync();
    logic [15:0] w;
    bit          found, bad;
    w = 16'hF00F;
    found = 1'b0;
    @(negedge clk);
    if1.in_data  = w;
    if1.in_valid = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (if1.frame_start) found = 1'b1;
    end
    total++;
    if (!found) $display("FAIL msb_start_timeout: no frame_start within 40 clk, required one");
    else passed++;
    bad = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clk);
      if (if1.ser_out !== w[15 - k / 16] || if1.frame_done) bad = 1'b1;
      if (k % 16 == 15) begin
        total++;
        if (bad) $display("FAIL msb_bit%0d: ser_out=%b, required %b for 16 clk", k / 16, if1.ser_out, w[15 - k / 16]);
        else passed++;
        bad = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if ({if1.frame_done, if1.ser_out, if1.ser_active} !== {1'b1, IDLE, 1'b0})
      $display("FAIL msb_done: done/ser/active=%b%b%b after 256 clk, required 1%b0",
               if1.frame_done, if1.ser_out, if1.ser_active, IDLE);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    fill_frame0(0, 16'h3C5A);
    fill_frame0(24, 16'hC3A5);
    offer0(16'h3C5A);
    wait_start0(n);
    check_stream0("b2b", 48, 50, 16'hC3A5);
    total++;
    if (acc_cnt != 1) $display("FAIL b2b_ready_low: %0d accepts seen, required 1", acc_cnt);
    else passed++;
    total++;
    if (fs_cnt != 2 || fd_cnt != 1)
      $display("FAIL b2b_pulses: frame_start=%0d frame_done=%0d, required 2 and 1", fs_cnt, fd_cnt);
    else passed++;
  endtask

  task automatic test_hold_on_load();
    int n;
    bit ok;
    fill_frame0(0, 16'h0F0F);
    fill_frame0(24, 16'h6699);
    ok = 1'b0;
    @(negedge clk);
    if0.in_data  = 16'h0F0F;
    if0.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!if0.in_ready) ok = 1'b1;
    end
    total++;
    if (!ok) $display("FAIL hold_first_accept: in_ready stayed 1, required 0");
    else passed++;
    if0.in_data = 16'h6699;             // in_valid stays high through the load edge
    offering    = 1'b1;
    wait_start0(n);
    total++;
    if (if0.in_ready !== 1'b1) $display("FAIL hold_not_taken_on_load: in_ready=%b, required 1", if0.in_ready);
    else passed++;
    check_stream0("hold", 48, -1, 16'h0000);
    total++;
    if (acc_cnt != 1 || fs_cnt != 2 || fd_cnt != 1)
      $display("FAIL hold_counts: accepts=%0d starts=%0d dones=%0d, required 1 2 1", acc_cnt, fs_cnt, fd_cnt);
    else passed++;
  endtask

  task automatic test_fast_phases();
    logic [3:0] words [0:3];
    logic [3:0] w;
    int         lat;
    bit         found, bad;
    words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'h9; words[3] = 4'h6;
    for (int t = 0; t < 4; t++) begin
      w = words[t];
      repeat (t) @(negedge clk);
      if2.in_data  = w;
      if2.in_valid = 1'b1;
      @(negedge clk);
      if2.in_valid = 1'b0;
      total++;
      if (if2.in_ready !== 1'b0) $display("FAIL fast%0d_accept: in_ready=%b, required 0", t, if2.in_ready);
      else passed++;
      found = 1'b0;
      lat = 0;
      for (int c = 1; c <= 4 && !found; c++) begin
        @(negedge clk);
        if (if2.ser_active) begin
          found = 1'b1;
          lat = c;
        end
      end
      total++;
      if (!found || lat < 1 || lat > 2) $display("FAIL fast%0d_latency: %0d clk, required 1..2", t, lat);
      else passed++;
      bad = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge clk);
        if (if2.ser_out !== w[k / 2] || if2.ser_active !== 1'b1) bad = 1'b1;
      end
      total++;
      if (bad) $display("FAIL fast%0d_bits: ser_out=%b at end, required %b with each bit held 2 clk", t, if2.ser_out, w);
      else passed++;
      @(negedge clk);
      total++;
      if ({if2.frame_done, if2.ser_out, if2.ser_active} !== {1'b1, IDLE, 1'b0})
        $display("FAIL fast%0d_done: done/ser/active=%b%b%b, required 1%b0",
                 t, if2.frame_done, if2.ser_out, if2.ser_active, IDLE);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    if0.in_data = '0; if0.in_valid = 1'b0;
    if1.in_data = '0; if1.in_valid = 1'b0;
    if2.in_data = '0; if2.in_valid = 1'b0;
    test_reset();
    test_frame_lsb();
    test_reset_mid_frame();
    test_msb_nosync();
    test_back_to_back();
    test_hold_on_load();
    test_fast_phases();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
